// File: rtl/theta_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | theta_pkg: shared widths, FSM states and column parity for slice theta.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package theta_pkg;

   localparam int SLICE_W  = 25;
   localparam int LANE_DIM = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRIME = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } theta_state_t;

   // Each 5-bit row holds x=0..4, so XOR of the rows is the column parity.
   function automatic logic [LANE_DIM-1:0] col_parity(input logic [SLICE_W-1:0] slice);
      logic [LANE_DIM-1:0] p;
      p = '0;
      for (int y = 0; y < LANE_DIM; y++) begin
         p = p ^ slice[y*LANE_DIM +: LANE_DIM];
      end
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/theta_slice_ctrl_slice_theta.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | slice_theta: combinational theta update of one slice given prior parity.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module slice_theta
   import theta_pkg::*;
(
   input  logic [SLICE_W-1:0]  slice,
   input  logic [LANE_DIM-1:0] c_prev,
   output logic [SLICE_W-1:0]  slice_out,
   output logic [LANE_DIM-1:0] c_cur
);

   logic [LANE_DIM-1:0] w_d;

   assign c_cur = col_parity(slice);

   generate
      for (genvar x = 0; x < LANE_DIM; x++) begin : g_d
         assign w_d[x] = c_cur[(x + LANE_DIM - 1) % LANE_DIM] ^ c_prev[(x + 1) % LANE_DIM];
      end
      for (genvar y = 0; y < LANE_DIM; y++) begin : g_row
         assign slice_out[y*LANE_DIM +: LANE_DIM] = slice[y*LANE_DIM +: LANE_DIM] ^ w_d;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/theta_slice_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | theta_slice_ctrl: walks the slice memory applying theta in place.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module theta_slice_ctrl
   import theta_pkg::*;
#(
   parameter int N_SLICES = 64,
   parameter int ADDR_W   = 6
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [SLICE_W-1:0] rd_data,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [SLICE_W-1:0] wr_data
);

   localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(N_SLICES - 1);

   theta_state_t        r_state;
   theta_state_t        w_state_nxt;
   logic [ADDR_W-1:0]   r_z;
   logic [ADDR_W-1:0]   w_z_nxt;
   logic [LANE_DIM-1:0] r_c_prev;
   logic [LANE_DIM-1:0] w_c_prev_nxt;
   logic [SLICE_W-1:0]  w_slice_out;
   logic [LANE_DIM-1:0] w_c_cur;

   slice_theta u_slice_theta (
      .slice     (rd_data),
      .c_prev    (r_c_prev),
      .slice_out (w_slice_out),
      .c_cur     (w_c_cur)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_z      <= '0;
         r_c_prev <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_z      <= w_z_nxt;
         r_c_prev <= w_c_prev_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_z_nxt      = r_z;
      w_c_prev_nxt = r_c_prev;
      busy         = 1'b0;
      done         = 1'b0;
      rd_en        = 1'b0;
      rd_addr      = '0;
      wr_en        = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_PRIME;
            end
         end

         // Slice N-1 is fetched first so its parity seeds the wrap to slice 0.
         ST_PRIME: begin
            busy        = 1'b1;
            rd_en       = 1'b1;
            rd_addr     = C_LAST;
            w_state_nxt = ST_LOAD;
         end

         ST_LOAD: begin
            busy         = 1'b1;
            rd_en        = 1'b1;
            rd_addr      = '0;
            w_c_prev_nxt = w_c_cur;
            w_z_nxt      = '0;
            w_state_nxt  = ST_RUN;
         end

         ST_RUN: begin
            busy         = 1'b1;
            wr_en        = 1'b1;
            wr_addr      = r_z;
            wr_data      = w_slice_out;
            w_c_prev_nxt = w_c_cur;
            if (r_z < C_LAST) begin
               rd_en   = 1'b1;
               rd_addr = r_z + 1'b1;
               w_z_nxt = r_z + 1'b1;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end

         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_theta_slice_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_theta_slice_ctrl: scoreboard bench, whole-state theta reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_theta_slice_ctrl;

   typedef logic [24:0] sq_t [$];
   typedef struct {
      int          t;
      int          addr;
      logic [24:0] data;
   } wexp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start64 = 1'b0;
   logic start4 = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int n_tests = 0;
   int n_fail = 0;

   logic        busy64, done64, rd_en64, wr_en64;
   logic [5:0]  rd_addr64, wr_addr64;
   logic [24:0] rd_data64 = '0;
   logic [24:0] wr_data64;
   logic        busy4, done4, rd_en4, wr_en4;
   logic [1:0]  rd_addr4, wr_addr4;
   logic [24:0] rd_data4 = '0;
   logic [24:0] wr_data4;

   logic [24:0] mem64 [64];
   logic [24:0] mem4 [4];
   sq_t   model64, model4;
   wexp_t wq64 [$];
   wexp_t wq4 [$];
   int    dq64 [$];
   int    dq4 [$];

   theta_slice_ctrl #(.N_SLICES(64), .ADDR_W(6)) dut64 (
      .clk(clk), .rst(rst), .start(start64), .busy(busy64), .done(done64),
      .rd_en(rd_en64), .rd_addr(rd_addr64), .rd_data(rd_data64),
      .wr_en(wr_en64), .wr_addr(wr_addr64), .wr_data(wr_data64)
   );

   theta_slice_ctrl #(.N_SLICES(4), .ADDR_W(2)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
      .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
      .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4)
   );

   // Slice memories: synchronous read, one-cycle latency
   always @(posedge clk) begin
      if (rd_en64) rd_data64 <= mem64[rd_addr64];
      if (wr_en64) mem64[wr_addr64] = wr_data64;
      if (rd_en4) rd_data4 <= mem4[rd_addr4];
      if (wr_en4) mem4[wr_addr4] = wr_data4;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Theta over the whole state: A[x,y,z] ^= C[x-1,z] ^ C[x+1,z-1]
   function automatic sq_t theta_ref(input sq_t s);
      sq_t         r;
      bit          par [$];
      int          n;
      logic [24:0] v;
      n = s.size();
      r = s;
      for (int z = 0; z < n; z++) begin
         for (int x = 0; x < 5; x++) begin
            bit p;
            p = 1'b0;
            for (int y = 0; y < 5; y++) p = p ^ s[z][5*y + x];
            par.push_back(p);
         end
      end
      for (int z = 0; z < n; z++) begin
         v = s[z];
         for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
               v[5*y + x] = s[z][5*y + x] ^ par[z*5 + (x + 4) % 5]
                            ^ par[((z + n - 1) % n)*5 + (x + 1) % 5];
            end
         end
         r[z] = v;
      end
      return r;
   endfunction

   task automatic push_pass(input bit big, input int b, input int nwr);
      sq_t   cur, nxt;
      wexp_t e;
      if (big) cur = model64; else cur = model4;
      nxt = theta_ref(cur);
      for (int z = 0; z < nwr; z++) begin
         e.t = b + 2 + z;
         e.addr = z;
         e.data = nxt[z];
         if (big) wq64.push_back(e); else wq4.push_back(e);
         cur[z] = nxt[z];
      end
      if (nwr == cur.size()) begin
         if (big) dq64.push_back(b + cur.size() + 2);
         else dq4.push_back(b + cur.size() + 2);
      end
      if (big) model64 = cur; else model4 = cur;
   endtask

   task automatic pass(input bit big, input int nwr, output int b);
      if (big) start64 = 1'b1; else start4 = 1'b1;
      b = edge_cnt;
      push_pass(big, b, nwr);
      @(negedge clk);
      start64 = 1'b0;
      start4 = 1'b0;
   endtask

   task automatic sync_models();
      model64.delete();
      model4.delete();
      for (int z = 0; z < 64; z++) model64.push_back(mem64[z]);
      for (int z = 0; z < 4; z++) model4.push_back(mem4[z]);
   endtask

   task automatic cmp_mems(input string name);
      int errs;
      errs = 0;
      for (int z = 0; z < 64; z++) if (mem64[z] !== model64[z]) errs++;
      for (int z = 0; z < 4; z++) if (mem4[z] !== model4[z]) errs++;
      chk(name, errs, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (wq64.size() + wq4.size() + dq64.size() + dq4.size()) != 0; i++)
         @(negedge clk);
      chk("drain_pending", wq64.size() + wq4.size() + dq64.size() + dq4.size(), 0);
      wq64.delete(); wq4.delete(); dq64.delete(); dq4.delete();
   endtask

   always @(negedge clk) begin : mon64
      wexp_t e;
      int    t;
      if (wr_en64) begin
         if (wq64.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL wr64_unexpected: addr %0d data %0h, none required", wr_addr64, wr_data64);
         end else begin
            e = wq64.pop_front();
            chk("wr64_cycle", edge_cnt - 1, e.t);
            chk("wr64_addr", wr_addr64, e.addr);
            chk("wr64_data", wr_data64, e.data);
            chk("wr64_busy", busy64, 1);
            if (rd_en64) chk("wr64_rd_addr_distinct", rd_addr64 != wr_addr64, 1);
         end
      end
      if (done64) begin
         if (dq64.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL done64_unexpected: at edge %0d, none required", edge_cnt - 1);
         end else begin
            t = dq64.pop_front();
            chk("done64_cycle", edge_cnt - 1, t);
            chk("busy64_at_done", busy64, 0);
         end
      end
   end

   always @(negedge clk) begin : mon4
      wexp_t e;
      int    t;
      if (wr_en4) begin
         if (wq4.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL wr4_unexpected: addr %0d data %0h, none required", wr_addr4, wr_data4);
         end else begin
            e = wq4.pop_front();
            chk("wr4_cycle", edge_cnt - 1, e.t);
            chk("wr4_addr", wr_addr4, e.addr);
            chk("wr4_data", wr_data4, e.data);
         end
      end
      if (done4) begin
         if (dq4.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL done4_unexpected: at edge %0d, none required", edge_cnt - 1);
         end else begin
            t = dq4.pop_front();
            chk("done4_cycle", edge_cnt - 1, t);
            chk("busy4_at_done", busy4, 0);
         end
      end
   end

   initial begin
      int          b;
      int          others;
      for (int z = 0; z < 64; z++) mem64[z] = '0;
      for (int z = 0; z < 4; z++) mem4[z] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", busy64, 0);
      chk("rst_done", done64, 0);
      chk("rst_rd_en", rd_en64, 0);
      chk("rst_wr_en", wr_en64, 0);
      chk("rst_rd_addr", rd_addr64, 0);
      chk("rst_wr_addr", wr_addr64, 0);
      chk("rst_wr_data", wr_data64, 0);
      chk("rst_busy4", busy4, 0);
      rst = 1'b0;
      @(negedge clk);

      // All-zero memory
      sync_models();
      pass(1'b1, 64, b);
      drain();
      cmp_mems("zero_mem");

      // Single bit in slice 63
      for (int z = 0; z < 64; z++) mem64[z] = '0;
      mem64[63] = 25'h1;
      sync_models();
      pass(1'b1, 64, b);
      drain();
      chk("bit63_slice0", mem64[0], 25'h1084210);
      chk("bit63_slice63", mem64[63], 25'h0210843);
      others = 0;
      for (int z = 1; z < 63; z++) if (mem64[z] != 0) others++;
      chk("bit63_others_zero", others, 0);

      // Random 64-slice state
      for (int z = 0; z < 64; z++) mem64[z] = 25'($urandom());
      sync_models();
      pass(1'b1, 64, b);
      drain();
      cmp_mems("random64");

      // Random 4-slice state
      for (int z = 0; z < 4; z++) mem4[z] = 25'($urandom());
      sync_models();
      pass(1'b0, 4, b);
      drain();
      cmp_mems("random4");

      // Start pulses during RUN and DONE must be ignored
      for (int z = 0; z < 64; z++) mem64[z] = 25'($urandom());
      sync_models();
      pass(1'b1, 64, b);
      while (edge_cnt < b + 5) @(negedge clk);
      start64 = 1'b1;
      @(negedge clk);
      start64 = 1'b0;
      while (edge_cnt < b + 67) @(negedge clk);
      start64 = 1'b1;
      @(negedge clk);
      start64 = 1'b0;
      drain();
      repeat (10) @(negedge clk);
      chk("no_restart_busy", busy64, 0);
      cmp_mems("ignored_starts");

      // Reset in cycle 10: slices 0..6 written, nothing after
      for (int z = 0; z < 64; z++) mem64[z] = 25'($urandom());
      sync_models();
      pass(1'b1, 7, b);
      while (edge_cnt < b + 9) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_wr_en", wr_en64, 0);
         chk("midrst_rd_en", rd_en64, 0);
         chk("midrst_busy", busy64, 0);
         chk("midrst_done", done64, 0);
      end
      chk("midrst_pending_writes", wq64.size(), 0);
      cmp_mems("midrst_partial");
      rst = 1'b0;
      @(negedge clk);
      pass(1'b1, 64, b);
      drain();
      cmp_mems("after_midrst");

      // Start held high for 200 cycles: passes at +0, +68, +136
      for (int z = 0; z < 64; z++) mem64[z] = 25'($urandom());
      sync_models();
      start64 = 1'b1;
      b = edge_cnt;
      push_pass(1'b1, b, 64);
      push_pass(1'b1, b + 68, 64);
      push_pass(1'b1, b + 136, 64);
      repeat (200) @(negedge clk);
      start64 = 1'b0;
      drain();
      repeat (10) @(negedge clk);
      chk("held_start_idle", busy64, 0);
      cmp_mems("held_start");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
